dm_unit: RTL and testbench

DM_UNIT -- requirements
Module: dm_unit

---
 rtl/dm_pkg.sv | 8 +
 rtl/dm_lane_align.sv | 29 ++
 rtl/dm_unit.sv | 83 ++++++++
 tb/tb_dm_unit.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// dm_pkg: shared size encodings and FSM states for the dm_unit data memory
package dm_pkg;
  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;
  typedef enum logic {ST_INIT, ST_RUN} dm_state_e;
endpackage

// File: rtl/dm_lane_align.sv
// dm_lane_align: byte enables, store lane merge and load extract/extend for one 32-bit word
// Ports: i_size/i_ld_unsigned/i_off select the access; i_wdata store data; i_old current word;
//        o_merged word to write back; o_ldata extracted and extended load value
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  i_size,
  input  logic        i_ld_unsigned,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_old,
  output logic [31:0] o_merged,
  output logic [31:0] o_ldata
);
  logic        w_byte, w_half;
  logic [3:0]  w_be;
  logic [31:0] w_rep, w_sh;
  assign w_byte = i_size == SZ_BYTE;
  assign w_half = i_size == SZ_HALF;
  always_comb begin
    w_be = w_byte ? 4'b0001 << i_off : w_half ? (i_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    w_rep = w_byte ? {4{i_wdata[7:0]}} : w_half ? {2{i_wdata[15:0]}} : i_wdata;
    o_merged = i_old;
    for (int k = 0; k < 4; k++) o_merged[8*k +: 8] = w_be[k] ? w_rep[8*k +: 8] : i_old[8*k +: 8];
    w_sh = i_old >> {i_off, 3'b000};
    o_ldata = w_byte ? {{24{~i_ld_unsigned & w_sh[7]}}, w_sh[7:0]}
            : w_half ? {{16{~i_ld_unsigned & w_sh[15]}}, w_sh[15:0]} : w_sh;
  end
endmodule

// File: rtl/dm_unit.sv
// dm_unit: single-cycle-latency byte-addressable data memory with a clear sweep after reset
// Ports: clk, reset (sync, active-low); req_valid/req_ready/we/size/ld_unsigned/addr/wdata request;
//        resp_valid/rdata/addr_exc response one cycle after acceptance; init_busy during clear sweep
// Optional: define DM_ALIGN_CHECK_EN to fault misaligned or out-of-range accesses
module dm_unit
  import dm_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              ld_unsigned,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       rdata,
  output logic              addr_exc,
  output logic              init_busy
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST = AW'(DEPTH_WORDS - 1);
  dm_state_e   r_state, w_next;
  logic [AW-1:0] r_cnt, w_idx, w_waddr;
  logic [31:0] r_mem [DEPTH_WORDS];
  logic [31:0] r_rdata, w_old, w_merged, w_ldata, w_wdata;
  logic [1:0]  w_off;
  logic        r_resp, r_exc, w_word, w_acc, w_exc, w_we, w_unused;
  always_comb begin
    w_next = (r_state == ST_INIT && r_cnt == LAST) ? ST_RUN : r_state;
    req_ready = r_state == ST_RUN;
    init_busy = r_state == ST_INIT;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_INIT;
      r_cnt   <= '0;
      r_resp  <= 1'b0;
      r_rdata <= '0;
      r_exc   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= init_busy ? r_cnt + AW'(1) : r_cnt;
      r_resp  <= w_acc;
      r_rdata <= (w_acc & ~we & ~w_exc) ? w_ldata : '0;
      r_exc   <= w_acc & w_exc;
    end
  end
  // Low offset bits are forced to natural alignment; with the check enabled the
  // misaligned cases fault anyway, so the forced offset never reaches memory.
  assign w_word = size == SZ_WORD || size == SZ_RSVD;
  assign w_off  = w_word ? 2'b00 : size == SZ_HALF ? {addr[1], 1'b0} : addr[1:0];
  assign w_idx  = addr[AW+1:2];
`ifdef DM_ALIGN_CHECK_EN
  assign w_exc = (size == SZ_HALF && addr[0]) || (w_word && |addr[1:0]) || |(addr >> (AW + 2));
`else
  assign w_exc = 1'b0;
`endif
  assign w_unused = ^addr;
  assign w_acc = req_valid & req_ready;
  assign w_old = r_mem[w_idx];
  dm_lane_align u_align (
    .i_size       (size),
    .i_ld_unsigned(ld_unsigned),
    .i_off        (w_off),
    .i_wdata      (wdata),
    .i_old        (w_old),
    .o_merged     (w_merged),
    .o_ldata      (w_ldata)
  );
  // The sweep and stores share the single write port; the sweep owns it during INIT.
  assign w_we    = init_busy | (w_acc & we & ~w_exc);
  assign w_waddr = init_busy ? r_cnt : w_idx;
  assign w_wdata = init_busy ? '0 : w_merged;
  always_ff @(posedge clk) if (w_we) r_mem[w_waddr] <= w_wdata;
  assign resp_valid = r_resp;
  assign rdata      = r_rdata;
  assign addr_exc   = r_exc;
endmodule

// File: tb/tb_dm_unit.sv
// tb_dm_unit: randomized and directed self-checking bench for dm_unit against a byte-array model
module tb_dm_unit;
  localparam int D = 16;
  logic        clk = 1'b0, reset = 1'b0, req_valid = 1'b0, req_ready, we = 1'b0, ld_unsigned = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic        resp_valid, addr_exc, init_busy;
  logic [7:0]  mb [4*D];
  logic        p_v = 1'b0, p_exc = 1'b0;
  logic [31:0] p_rd = '0;
  int          n_chk = 0, n_err = 0;
  dm_unit #(.DEPTH_WORDS(D), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .we(we),
    .size(size), .ld_unsigned(ld_unsigned), .addr(addr), .wdata(wdata),
    .resp_valid(resp_valid), .rdata(rdata), .addr_exc(addr_exc), .init_busy(init_busy)
  );
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic int unsigned nbytes(input logic [1:0] s);
    return s == 2'b10 ? 1 : s == 2'b01 ? 2 : 4;
  endfunction
  function automatic logic m_exc(input logic [31:0] a, input logic [1:0] s);
`ifdef DM_ALIGN_CHECK_EN
    return (nbytes(s) == 2 && a[0]) || (nbytes(s) == 4 && a[1:0] != 2'b00) || a >= 32'(4*D);
`else
    return 1'b0;
`endif
  endfunction
  function automatic int unsigned m_base(input logic [31:0] a, input logic [1:0] s);
    return (a % (4*D)) / nbytes(s) * nbytes(s);
  endfunction
  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] s, input logic u);
    int unsigned n = nbytes(s), b = m_base(a, s);
    logic [31:0] v = '0;
    for (int i = 0; i < 4; i++) if (i < n) v |= 32'(mb[b+i]) << (8*i);
    if (!u && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction
  task automatic m_store(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
    int unsigned n = nbytes(s), b = m_base(a, s);
    for (int i = 0; i < 4; i++) if (i < n) mb[b+i] = d[8*i +: 8];
  endtask
  task automatic issue(input logic v, input logic w, input logic [1:0] s, input logic u,
                       input logic [31:0] a, input logic [31:0] d);
    chk("resp_valid", 32'(resp_valid), 32'(p_v));
    chk("rdata", rdata, p_rd);
    chk("addr_exc", 32'(addr_exc), 32'(p_exc));
    if (v) chk("req_ready", 32'(req_ready), 32'd1);
    req_valid = v; we = w; size = s; ld_unsigned = u; addr = a; wdata = d;
    p_v = v;
    p_exc = v && m_exc(a, s);
    p_rd = '0;
    if (v && !p_exc) begin
      if (w) m_store(a, s, d);
      else p_rd = m_load(a, s, u);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask
  task automatic reset_and_sweep();
    int n = 0;
    reset = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_addr_exc", 32'(addr_exc), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_init_busy", 32'(init_busy), 32'd1);
    reset = 1'b1;
    for (int i = 0; i < 4*D; i++) mb[i] = 8'h00;
    p_v = 1'b0; p_exc = 1'b0; p_rd = '0;
    while (init_busy && n < 4*D) begin
      n++;
      @(negedge clk);
    end
    chk("sweep_len", 32'(n), 32'(D));
    chk("ready_after_sweep", 32'(req_ready), 32'd1);
  endtask
  initial begin
    reset_and_sweep();
    issue(1, 0, 2'b00, 0, 32'h0, 32'h0);
    issue(1, 1, 2'b10, 0, 32'h1, 32'h87654321);
    issue(1, 0, 2'b00, 0, 32'h0, 32'h0);
    p_rd = 32'h00002100;
    issue(1, 1, 2'b01, 0, 32'h2, 32'h87654321);
    issue(1, 0, 2'b00, 0, 32'h0, 32'h0);
    p_rd = 32'h43212100;
    issue(1, 1, 2'b00, 0, 32'h0, 32'h87654321);
    issue(1, 0, 2'b10, 0, 32'h3, 32'h0);
    p_rd = 32'hFFFFFF87;
    issue(1, 0, 2'b10, 1, 32'h3, 32'h0);
    p_rd = 32'h00000087;
    issue(1, 0, 2'b01, 0, 32'h2, 32'h0);
    p_rd = 32'hFFFF8765;
    issue(1, 0, 2'b01, 1, 32'h1, 32'h0);
`ifndef DM_ALIGN_CHECK_EN
    p_rd = 32'h00004321;
`endif
    issue(1, 1, 2'b00, 0, 32'h2, 32'h11112222);
    issue(1, 0, 2'b00, 0, 32'h0, 32'h0);
    issue(1, 1, 2'b00, 0, 32'h8, 32'hDEADBEEF);
    issue(1, 0, 2'b00, 0, 32'h8, 32'h0);
    p_rd = 32'hDEADBEEF;
    repeat (400) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4*D-1));
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            $urandom_range(0, 1) == 1, a, $urandom);
    end
    issue(0, 0, 2'b00, 0, 32'h0, 32'h0);
    issue(1, 1, 2'b00, 0, 32'h8, 32'hDEADBEEF);
    issue(1, 0, 2'b00, 0, 32'h8, 32'h0);
    chk("inflight_resp_valid", 32'(resp_valid), 32'd1);
    chk("inflight_rdata", rdata, 32'hDEADBEEF);
    reset = 1'b0;
    @(negedge clk);
    chk("dropped_resp_valid", 32'(resp_valid), 32'd0);
    chk("reinit_busy", 32'(init_busy), 32'd1);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset_and_sweep();
    issue(1, 0, 2'b00, 0, 32'h8, 32'h0);
    p_rd = 32'h0;
    issue(0, 0, 2'b00, 0, 32'h0, 32'h0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
